// File: rtl/popcount_seq_ctrl.sv
// ============================================================================
// popcount_seq_ctrl
// ----------------------------------------------------------------------------
// Counts the 1 bits of a wide word using a narrow ones-counter. The counter
// is reused once per cycle, one CHUNK_WIDTH slice at a time, starting with
// the least significant slice. The slice counts are summed, and the total is
// returned on a valid/ready output.
//
// Parameters
//   DATA_WIDTH   width of the input word; must be a multiple of CHUNK_WIDTH
//   CHUNK_WIDTH  slice width counted per cycle
//   CNT_W        derived; wide enough to hold 0..DATA_WIDTH
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous reset, active-low
//   in_valid   input word valid
//   in_ready   controller can accept a word (high only when idle)
//   in_data    word to count
//   out_valid  out_count valid; held until out_ready
//   out_ready  consumer accepts out_count
//   out_count  number of 1 bits in the accepted word
//   busy       a word is being counted or its result is pending
//
// Build option
//   POPCNT_EARLY_EXIT_EN  when defined, counting stops as soon as every
//                         remaining upper slice is zero. The latency then
//                         varies from 1 to NUM_CHUNKS cycles; the result is
//                         unchanged.
// ============================================================================
module popcount_seq_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int CHUNK_WIDTH = 8,
    localparam int CNT_W      = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CNT_W-1:0]      out_count,
    output logic                  busy
);

    localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] data_q;
    logic [IDX_W-1:0]      idx;
    logic [CNT_W-1:0]      acc;
    logic [CNT_W-1:0]      acc_next;
    logic                  last_slice;

    // Ones in slice i of w. The bit loop covers the whole word, so that no
    // part-select can fall outside the word for any slice index.
    function automatic logic [CNT_W-1:0] slice_count(
        input logic [DATA_WIDTH-1:0] w,
        input logic [IDX_W-1:0]      i
    );
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int b = 0; b < DATA_WIDTH; b++) begin
            if ((b / CHUNK_WIDTH) == int'(i)) begin
                cnt = cnt + CNT_W'(w[b]);
            end
        end
        return cnt;
    endfunction

`ifdef POPCNT_EARLY_EXIT_EN
    // OR-reduce of every bit that lies above slice i.
    function automatic logic upper_nonzero(
        input logic [DATA_WIDTH-1:0] w,
        input logic [IDX_W-1:0]      i
    );
        logic nz;
        nz = 1'b0;
        for (int b = 0; b < DATA_WIDTH; b++) begin
            if ((b / CHUNK_WIDTH) > int'(i)) begin
                nz = nz | w[b];
            end
        end
        return nz;
    endfunction
`endif

    always_comb begin
        acc_next = acc + slice_count(data_q, idx);
`ifdef POPCNT_EARLY_EXIT_EN
        last_slice = (idx == LAST_IDX) || !upper_nonzero(data_q, idx);
`else
        last_slice = (idx == LAST_IDX);
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            data_q    <= '0;
            idx       <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_count <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data_q   <= in_data;
                        acc      <= '0;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= COUNT;
                    end
                end
                COUNT: begin
                    acc <= acc_next;
                    idx <= idx + 1'b1;
                    // The final sum is moved to the output on the same edge
                    // as the last slice is added. DONE therefore presents a
                    // stable result with no extra cycle.
                    if (last_slice) begin
                        out_count <= acc_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        idx       <= '0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_popcount_seq_ctrl.sv
module tb_popcount_seq_ctrl;

    localparam int DATA_WIDTH  = 32;
    localparam int CHUNK_WIDTH = 8;
    localparam int CNT_W       = $clog2(DATA_WIDTH) + 1;
    localparam int TIMEOUT     = 50;

    logic                  clk;
    logic                  rst_n;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [CNT_W-1:0]      out_count;
    logic                  busy;

    int tests;
    int fails;

    popcount_seq_ctrl #(
        .DATA_WIDTH (DATA_WIDTH),
        .CHUNK_WIDTH(CHUNK_WIDTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_count(out_count),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          count;
        int          lat_full;
        int          lat_early;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int actual, input int expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present d and hold in_valid until the word is taken. On return, the
    // accepting edge has just passed.
    task automatic accept_word(input logic [31:0] d, input bit drop_valid);
        int n;
        in_data  = d;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < TIMEOUT) begin
            tick();
            n++;
        end
        check("accept_timeout", int'(n < TIMEOUT), 1);
        tick();
        if (drop_valid) in_valid = 1'b0;
    endtask

    // Count the edges from the accepting edge to out_valid.
    task automatic wait_result(output int lat);
        lat = 1;
        while (!out_valid && lat <= TIMEOUT) begin
            tick();
            lat++;
        end
        lat = lat - 1;
    endtask

    function automatic int exp_latency(input vec_t v);
`ifdef POPCNT_EARLY_EXIT_EN
        return v.lat_early;
`else
        return v.lat_full;
`endif
    endfunction

    initial begin
        int lat;
        int seen;
        vec_t v;
        logic [31:0] words[3];
        int          wcnt[3];

        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;

        vecs[0] = '{32'hFFFF_FFFF, 32, 4, 4};
        vecs[1] = '{32'h0000_0000,  0, 4, 1};
        vecs[2] = '{32'h8000_0001,  2, 4, 4};
        vecs[3] = '{32'h0000_00F0,  4, 4, 1};
        vecs[4] = '{32'hA5A5_A5A5, 16, 4, 4};
        vecs[5] = '{32'h0000_0001,  1, 4, 1};
        vecs[6] = '{32'h1234_5678, 13, 4, 4};
        vecs[7] = '{32'h00FF_0000,  8, 4, 3};

        // Reset state
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_count", int'(out_count), 0);
        check("rst_busy", int'(busy), 0);

        // Table-driven vectors
        for (int i = 0; i < 8; i++) begin
            v = vecs[i];
            accept_word(v.data, 1'b1);
            check("busy_after_accept", int'(busy), 1);
            check("in_ready_low", int'(in_ready), 0);
            wait_result(lat);
            check($sformatf("latency[%0d]", i), lat, exp_latency(v));
            check($sformatf("count[%0d]", i), int'(out_count), v.count);
            tick();
            check($sformatf("ovalid_drop[%0d]", i), int'(out_valid), 0);
            check($sformatf("in_ready_back[%0d]", i), int'(in_ready), 1);
        end

        // T4: back-pressure holds the result; input is ignored meanwhile
        out_ready = 1'b0;
        accept_word(32'hA5A5_A5A5, 1'b1);
        wait_result(lat);
        check("t4_latency", lat, 4);
        for (int c = 0; c < 5; c++) begin
            in_data  = 32'hFFFF_FFFF;
            in_valid = (c % 2 == 0);
            tick();
            check("t4_hold_valid", int'(out_valid), 1);
            check("t4_hold_count", int'(out_count), 16);
            check("t4_in_ready", int'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("t4_released", int'(out_valid), 0);
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (out_valid) seen++;
        end
        check("t4_no_second_result", seen, 0);
        check("t4_idle_busy", int'(busy), 0);

        // T5: reset during the second COUNT cycle discards the word
        accept_word(32'hFFFF_FFFF, 1'b1);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t5_in_ready", int'(in_ready), 1);
        check("t5_busy", int'(busy), 0);
        check("t5_out_valid", int'(out_valid), 0);
        check("t5_out_count", int'(out_count), 0);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (out_valid) seen++;
        end
        check("t5_no_out_valid", seen, 0);
        accept_word(32'h0000_0003, 1'b1);
        wait_result(lat);
        check("t5_next_count", int'(out_count), 2);
        tick();

        // T6: back-to-back words with in_valid held high
        words[0] = 32'h1; wcnt[0] = 1;
        words[1] = 32'h3; wcnt[1] = 2;
        words[2] = 32'h7; wcnt[2] = 3;
        for (int w = 0; w < 3; w++) begin
            accept_word(words[w], w == 2);
            if (w < 2) in_data = words[w + 1];
            wait_result(lat);
`ifdef POPCNT_EARLY_EXIT_EN
            check($sformatf("t6_latency[%0d]", w), lat, 1);
`else
            check($sformatf("t6_latency[%0d]", w), lat, 4);
`endif
            check($sformatf("t6_count[%0d]", w), int'(out_count), wcnt[w]);
            tick();
        end
        in_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
